// File: rtl/ethernet_tx_buffer.sv
// Byte-addressable TX frame buffer streamed out as 32-bit beats with keep/last and a sticky frame-sent interrupt.
// Optional feature: define ETH_TX_MIN_FRAME_PAD_EN to zero-pad short frames up to 60 bytes.
module ethernet_tx_buffer #(
  parameter int eth_mtu_p    = 2048,
  parameter int data_width_p = 32
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        packet_wvalid_i,
  input  logic [10:0] packet_waddr_i,
  input  logic [31:0] packet_wdata_i,
  input  logic [1:0]  packet_wdata_size_i,
  input  logic        packet_wsize_valid_i,
  input  logic [11:0] packet_wsize_i,
  input  logic        packet_send_i,
  output logic        packet_req_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [31:0] tx_data_o,
  output logic [3:0]  tx_keep_o,
  output logic        tx_last_o,
  input  logic        tx_interrupt_clear_i,
  input  logic        tx_interrupt_enable_i,
  input  logic        tx_interrupt_enable_v_i,
  output logic        tx_interrupt_pending_o,
  output logic        tx_irq_o
);

  localparam int words_lp = eth_mtu_p / 4;
  localparam int aw_lp    = $clog2(words_lp);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [data_width_p-1:0] mem [words_lp];

  logic [0:0]  state;
  logic [11:0] len;
  logic [9:0]  beat;
  logic        tx_valid, tx_last, pending, enable;
  logic [31:0] tx_data;
  logic [3:0]  tx_keep;

  // Write path: replicate narrow data across lanes and pick lanes with byte enables.
  logic [3:0]       be;
  logic [31:0]      wsh;
  logic [aw_lp-1:0] widx;
  logic             we;

  always_comb begin
    be  = 4'hF;
    wsh = packet_wdata_i;
    case (packet_wdata_size_i)
      2'd0: begin
        be  = 4'b0001 << packet_waddr_i[1:0];
        wsh = {4{packet_wdata_i[7:0]}};
      end
      2'd1: begin
        be  = packet_waddr_i[1] ? 4'b1100 : 4'b0011;
        wsh = {2{packet_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign widx = packet_waddr_i[aw_lp+1:2];
  assign we   = packet_wvalid_i && (state == IDLE);

  always_ff @(posedge clk_i) begin
    if (we)
      for (int j = 0; j < 4; j++)
        if (be[j]) mem[widx][8*j +: 8] <= wsh[8*j +: 8];
  end

  // Effective frame length; padding bytes come from the read mask, never from the buffer.
  logic [11:0] eff_len;
`ifdef ETH_TX_MIN_FRAME_PAD_EN
  assign eff_len = (len < 12'd60) ? 12'd60 : len;
`else
  assign eff_len = len;
`endif

  logic [9:0] last_beat;
  logic [3:0] last_keep;

  assign last_beat = 10'((eff_len - 12'd1) >> 2);

  always_comb begin
    case (eff_len[1:0])
      2'd1:    last_keep = 4'h1;
      2'd2:    last_keep = 4'h3;
      2'd3:    last_keep = 4'h7;
      default: last_keep = 4'hF;
    endcase
  end

  // The output register doubles as the synchronous read port: it is loaded with the
  // next beat whenever it is empty or its current beat is being accepted.
  logic [9:0]  rd_beat;
  logic [31:0] rd_mask;
  logic        load, done;

  assign rd_beat = tx_valid ? beat + 10'd1 : 10'd0;
  assign load    = (state == SEND) && (!tx_valid || (tx_ready_i && !tx_last));
  assign done    = (state == SEND) && tx_valid && tx_ready_i && tx_last;

  always_comb begin
    rd_mask = '0;
    for (int j = 0; j < 4; j++)
      rd_mask[8*j +: 8] = ({rd_beat, 2'(j)} < len) ? 8'hFF : 8'h00;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state    <= IDLE;
      len      <= '0;
      beat     <= '0;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
      tx_keep  <= '0;
      tx_data  <= '0;
      pending  <= 1'b0;
      enable   <= 1'b0;
    end else begin
      if (tx_interrupt_enable_v_i) enable <= tx_interrupt_enable_i;

      // Set wins over clear.
      if (done)                      pending <= 1'b1;
      else if (tx_interrupt_clear_i) pending <= 1'b0;

      case (state)
        IDLE: begin
          if (packet_wsize_valid_i) len <= packet_wsize_i;
          if (packet_send_i && (len != 12'd0) && (len <= 12'(eth_mtu_p)))
            state <= SEND;
        end
        default: begin
          if (load) begin
            tx_valid <= 1'b1;
            tx_data  <= mem[rd_beat[aw_lp-1:0]] & rd_mask;
            tx_keep  <= (rd_beat == last_beat) ? last_keep : 4'hF;
            tx_last  <= (rd_beat == last_beat);
            beat     <= rd_beat;
          end else if (done) begin
            state    <= IDLE;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            tx_keep  <= '0;
            tx_data  <= '0;
          end
        end
      endcase
    end
  end

  assign packet_req_o           = (state == IDLE);
  assign tx_valid_o             = tx_valid;
  assign tx_data_o              = tx_data;
  assign tx_keep_o              = tx_keep;
  assign tx_last_o              = tx_last;
  assign tx_interrupt_pending_o = pending;
  assign tx_irq_o               = pending & enable;

endmodule

// File: tb/tb_ethernet_tx_buffer.sv
// Directed bench for ethernet_tx_buffer: writes, framing, stalls, bad lengths, reset abort, interrupt.
module tb_ethernet_tx_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wvalid;
  logic [10:0] waddr;
  logic [31:0] wdata;
  logic [1:0]  wdata_size;
  logic        wsize_valid;
  logic [11:0] wsize;
  logic        send;
  logic        req;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] tx_data;
  logic [3:0]  tx_keep;
  logic        tx_last;
  logic        irq_clear, irq_en, irq_en_v;
  logic        pending, irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] acc_data[$];
  logic [3:0]  acc_keep[$];
  logic        acc_last[$];

  always #5 clk = ~clk;

  ethernet_tx_buffer dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .packet_wvalid_i(wvalid), .packet_waddr_i(waddr), .packet_wdata_i(wdata),
    .packet_wdata_size_i(wdata_size), .packet_wsize_valid_i(wsize_valid),
    .packet_wsize_i(wsize), .packet_send_i(send), .packet_req_o(req),
    .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .tx_data_o(tx_data),
    .tx_keep_o(tx_keep), .tx_last_o(tx_last),
    .tx_interrupt_clear_i(irq_clear), .tx_interrupt_enable_i(irq_en),
    .tx_interrupt_enable_v_i(irq_en_v), .tx_interrupt_pending_o(pending),
    .tx_irq_o(irq)
  );

  // Beats accepted at the coming rising edge (inputs settle 1ns after each edge).
  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin
      acc_data.push_back(tx_data);
      acc_keep.push_back(tx_keep);
      acc_last.push_back(tx_last);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [10:0] a, input logic [31:0] d, input logic [1:0] s);
    wvalid = 1'b1; waddr = a; wdata = d; wdata_size = s;
    tick();
    wvalid = 1'b0;
  endtask

  task automatic set_len(input logic [11:0] l);
    wsize_valid = 1'b1; wsize = l;
    tick();
    wsize_valid = 1'b0;
  endtask

  task automatic pulse_send();
    send = 1'b1;
    tick();
    send = 1'b0;
  endtask

  task automatic pulse_clear();
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
  endtask

  task automatic clear_acc();
    acc_data.delete(); acc_keep.delete(); acc_last.delete();
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tx_valid) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (req && !tx_valid) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    checks++; if (req !== 1'b1)      begin errors++; $display("FAIL reset_req got %0b exp 1", req); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", tx_valid); end
    checks++; if ({tx_last, tx_keep, tx_data} !== 37'd0)
      begin errors++; $display("FAIL reset_out got last=%0b keep=%h data=%h exp 0", tx_last, tx_keep, tx_data); end
    checks++; if ({pending, irq} !== 2'b00) begin errors++; $display("FAIL reset_irq got %b exp 00", {pending, irq}); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    clear_acc();
    tx_ready = 1'b1;
    wr(11'd0, 32'h03020100, 2'd2);
    wr(11'd4, 32'h07060504, 2'd2);
    set_len(12'd7);
    pulse_send();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL basic_lat1 got valid=%0b exp 0", tx_valid); end
    tick();
    checks++; if ({tx_valid, tx_data, tx_keep, tx_last} !== {1'b1, 32'h03020100, 4'hF, 1'b0})
      begin errors++; $display("FAIL basic_beat0 got v=%0b d=%h k=%h l=%0b exp 1 03020100 f 0", tx_valid, tx_data, tx_keep, tx_last); end
    tick();
    checks++; if ({tx_valid, tx_data, tx_keep, tx_last} !== {1'b1, 32'h00060504, 4'h7, 1'b1})
      begin errors++; $display("FAIL basic_beat1 got v=%0b d=%h k=%h l=%0b exp 1 00060504 7 1", tx_valid, tx_data, tx_keep, tx_last); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL basic_pend_early got %0b exp 0", pending); end
    tick();
    checks++; if ({tx_valid, req, pending, irq} !== 4'b0110)
      begin errors++; $display("FAIL basic_done got v/req/pend/irq=%b exp 0110", {tx_valid, req, pending, irq}); end
    checks++; if (acc_data.size() !== 2) begin errors++; $display("FAIL basic_count got %0d exp 2", acc_data.size()); end
  endtask

  task automatic test_stall();
    bit ok;
    pulse_clear();
    clear_acc();
    tx_ready = 1'b1;
    wr(11'd0, 32'h0B0A0908, 2'd2);
    wr(11'd4, 32'h0F0E0D0C, 2'd2);
    set_len(12'd8);
    pulse_send();
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_timeout got no valid exp valid"); end
    checks++; if (tx_data !== 32'h0B0A0908) begin errors++; $display("FAIL stall_beat0 got %h exp 0b0a0908", tx_data); end
    tick();
    tx_ready = 1'b0;
    checks++; if ({tx_valid, tx_data, tx_keep, tx_last} !== {1'b1, 32'h0F0E0D0C, 4'hF, 1'b1})
      begin errors++; $display("FAIL stall_beat1 got v=%0b d=%h k=%h l=%0b exp 1 0f0e0d0c f 1", tx_valid, tx_data, tx_keep, tx_last); end
    // Buffer write while sending must be dropped.
    wr(11'd0, 32'hFFFFFFFF, 2'd2);
    checks++; if ({tx_valid, tx_data, tx_keep, tx_last} !== {1'b1, 32'h0F0E0D0C, 4'hF, 1'b1})
      begin errors++; $display("FAIL stall_hold1 got v=%0b d=%h k=%h l=%0b exp 1 0f0e0d0c f 1", tx_valid, tx_data, tx_keep, tx_last); end
    // Length write and send while sending must be dropped.
    wsize_valid = 1'b1; wsize = 12'd4; send = 1'b1;
    tick();
    wsize_valid = 1'b0; send = 1'b0;
    checks++; if ({tx_valid, tx_data, tx_keep, tx_last} !== {1'b1, 32'h0F0E0D0C, 4'hF, 1'b1})
      begin errors++; $display("FAIL stall_hold2 got v=%0b d=%h k=%h l=%0b exp 1 0f0e0d0c f 1", tx_valid, tx_data, tx_keep, tx_last); end
    tx_ready = 1'b1;
    tick();
    checks++; if ({tx_valid, req, pending} !== 3'b011) begin errors++; $display("FAIL stall_done got %b exp 011", {tx_valid, req, pending}); end
    checks++; if (acc_data.size() !== 2) begin errors++; $display("FAIL stall_count got %0d exp 2", acc_data.size()); end
    else begin
      checks++; if ({acc_data[0], acc_data[1], acc_last[0], acc_last[1]} !== {32'h0B0A0908, 32'h0F0E0D0C, 1'b0, 1'b1})
        begin errors++; $display("FAIL stall_beats got %h %h exp 0b0a0908 0f0e0d0c", acc_data[0], acc_data[1]); end
    end
    repeat (3) tick();
    checks++; if ({req, tx_valid} !== 2'b10) begin errors++; $display("FAIL stall_no_restart got req/v=%b exp 10", {req, tx_valid}); end
    // Resend: length and buffer must be unchanged by the dropped writes.
    clear_acc();
    pulse_send();
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL resend_timeout got busy exp idle"); end
    checks++; if (acc_data.size() !== 2) begin errors++; $display("FAIL resend_count got %0d exp 2", acc_data.size()); end
    else begin
      checks++; if (acc_data[0] !== 32'h0B0A0908) begin errors++; $display("FAIL resend_beat0 got %h exp 0b0a0908", acc_data[0]); end
    end
  endtask

  task automatic test_partial_writes();
    bit ok;
    clear_acc();
    tx_ready = 1'b1;
    wr(11'd0, 32'h00000000, 2'd2);
    wr(11'd1, 32'hAAAAAAEE, 2'd0);
    wr(11'd3, 32'hFFFF1234, 2'd1);
    wr(11'd6, 32'h44332211, 2'd2);
    set_len(12'd5);
    pulse_send();
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL partial_timeout got busy exp idle"); end
    checks++; if (acc_data.size() !== 2) begin errors++; $display("FAIL partial_count got %0d exp 2", acc_data.size()); end
    else begin
      checks++; if ({acc_data[0], acc_keep[0], acc_last[0]} !== {32'h1234EE00, 4'hF, 1'b0})
        begin errors++; $display("FAIL partial_beat0 got %h k=%h exp 1234ee00 f", acc_data[0], acc_keep[0]); end
      checks++; if ({acc_data[1], acc_keep[1], acc_last[1]} !== {32'h00000011, 4'h1, 1'b1})
        begin errors++; $display("FAIL partial_beat1_l5 got %h k=%h exp 00000011 1", acc_data[1], acc_keep[1]); end
    end
    clear_acc();
    set_len(12'd6);
    pulse_send();
    wait_idle(ok);
    checks++; if (acc_data.size() !== 2) begin errors++; $display("FAIL l6_count got %0d exp 2", acc_data.size()); end
    else begin
      checks++; if ({acc_data[1], acc_keep[1]} !== {32'h00002211, 4'h3})
        begin errors++; $display("FAIL l6_beat1 got %h k=%h exp 00002211 3", acc_data[1], acc_keep[1]); end
    end
  endtask

  task automatic test_bad_len();
    logic [11:0] lens [2];
    lens[0] = 12'd0;
    lens[1] = 12'd2049;
    pulse_clear();
    tx_ready = 1'b1;
    for (int n = 0; n < 2; n++) begin
      set_len(lens[n]);
      pulse_send();
      for (int i = 0; i < 4; i++) begin
        checks++; if ({req, tx_valid, pending} !== 3'b100)
          begin errors++; $display("FAIL badlen_%0d got req/v/pend=%b exp 100", lens[n], {req, tx_valid, pending}); end
        tick();
      end
    end
  endtask

  task automatic test_midframe_reset();
    bit ok;
    irq_en = 1'b1; irq_en_v = 1'b1;
    tick();
    irq_en_v = 1'b0;
    tx_ready = 1'b1;
    set_len(12'd8);
    pulse_send();
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_timeout got no valid exp valid"); end
    tick();
    reset_n = 1'b0;
    #1;
    checks++; if ({tx_valid, req, pending, tx_last, tx_keep, tx_data} !== {3'b010, 37'd0})
      begin errors++; $display("FAIL abort_async got v=%0b req=%0b pend=%0b d=%h", tx_valid, req, pending, tx_data); end
    #2;
    reset_n = 1'b1;
    clear_acc();
    repeat (4) tick();
    checks++; if ({tx_valid, pending, irq, acc_data.size() == 0} !== 4'b0001)
      begin errors++; $display("FAIL abort_resume got v/pend/irq/none=%b exp 0001", {tx_valid, pending, irq, acc_data.size() == 0}); end
    wr(11'd0, 32'hDDCCBBAA, 2'd2);
    set_len(12'd4);
    pulse_send();
    wait_valid(ok);
    checks++; if ({ok, tx_data, tx_keep, tx_last} !== {1'b1, 32'hDDCCBBAA, 4'hF, 1'b1})
      begin errors++; $display("FAIL abort_new got ok=%0b d=%h k=%h l=%0b exp 1 ddccbbaa f 1", ok, tx_data, tx_keep, tx_last); end
    tick();
    checks++; if ({req, tx_valid, pending, irq} !== 4'b1010)
      begin errors++; $display("FAIL abort_new_done got %b exp 1010", {req, tx_valid, pending, irq}); end
  endtask

  task automatic test_irq();
    bit ok;
    irq_en = 1'b1; irq_en_v = 1'b1;
    tick();
    irq_en_v = 1'b0;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_enable got %0b exp 1", irq); end
    pulse_clear();
    checks++; if ({pending, irq} !== 2'b00) begin errors++; $display("FAIL irq_clear got %b exp 00", {pending, irq}); end
    tx_ready = 1'b1;
    pulse_send();
    wait_valid(ok);
    checks++; if (!(ok && tx_last)) begin errors++; $display("FAIL irq_frame got ok=%0b last=%0b exp 1 1", ok, tx_last); end
    irq_clear = 1'b1;
    tick();
    checks++; if ({pending, irq} !== 2'b11) begin errors++; $display("FAIL irq_set_wins got %b exp 11", {pending, irq}); end
    tick();
    irq_clear = 1'b0;
    checks++; if ({pending, irq} !== 2'b00) begin errors++; $display("FAIL irq_cleared got %b exp 00", {pending, irq}); end
    irq_en = 1'b0; irq_en_v = 1'b1;
    tick();
    irq_en_v = 1'b0;
    pulse_send();
    wait_idle(ok);
    checks++; if ({ok, pending, irq} !== 3'b110) begin errors++; $display("FAIL irq_masked got %b exp 110", {ok, pending, irq}); end
  endtask

`ifdef ETH_TX_MIN_FRAME_PAD_EN
  task automatic test_pad();
    bit ok;
    clear_acc();
    tx_ready = 1'b1;
    for (int w = 0; w < 4; w++)
      wr(11'(4*w), {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}, 2'd2);
    set_len(12'd14);
    pulse_send();
    wait_idle(ok);
    checks++; if (acc_data.size() !== 15) begin errors++; $display("FAIL pad_count got %0d exp 15", acc_data.size()); end
    else begin
      checks++; if (acc_data[3] !== 32'h00000D0C) begin errors++; $display("FAIL pad_beat3 got %h exp 00000d0c", acc_data[3]); end
      for (int b = 4; b < 15; b++) begin
        checks++; if (acc_data[b] !== 32'h0) begin errors++; $display("FAIL pad_zero%0d got %h exp 0", b, acc_data[b]); end
      end
      checks++; if ({acc_keep[14], acc_last[14]} !== {4'hF, 1'b1})
        begin errors++; $display("FAIL pad_last got k=%h l=%0b exp f 1", acc_keep[14], acc_last[14]); end
    end
  endtask
`endif

  initial begin
    reset_n = 1'b0; wvalid = 1'b0; waddr = '0; wdata = '0; wdata_size = '0;
    wsize_valid = 1'b0; wsize = '0; send = 1'b0; tx_ready = 1'b0;
    irq_clear = 1'b0; irq_en = 1'b0; irq_en_v = 1'b0;
    #1;
    test_reset();
`ifdef ETH_TX_MIN_FRAME_PAD_EN
    test_pad();
`else
    test_basic();
    test_stall();
    test_partial_writes();
    test_bad_len();
    test_midframe_reset();
    test_irq();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
